// File: rtl/cfg_image_loader_if.sv
// Image-memory read port and fabric configuration write port of cfg_image_loader.
// master = loader side, slave = image memory / fabric side.
interface cfg_image_loader_if #(
    parameter int ADDR_W = 8
);
    logic              img_rd;
    logic [ADDR_W-1:0] img_addr;
    logic [31:0]       img_data;
    logic              cfg_we;
    logic              cfg_type;
    logic [7:0]        cfg_index;
    logic [32:0]       cfg_data;

    modport master (
        output img_rd, img_addr, cfg_we, cfg_type, cfg_index, cfg_data,
        input  img_data
    );

    modport slave (
        input  img_rd, img_addr, cfg_we, cfg_type, cfg_index, cfg_data,
        output img_data
    );
endinterface

// File: rtl/cfg_image_loader.sv
// Walks a configuration image (descriptor/payload pairs, END-terminated) and issues LUT / switch-block
// configuration write strobes. Optional macro CFG_CHECKSUM_EN adds an XOR checksum word after END.
module cfg_image_loader #(
    parameter int ADDR_W  = 8,
    parameter int NUM_LUT = 24,
    parameter int NUM_SW  = 17
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    cfg_image_loader_if.master  bus,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [1:0]          err_code,
    output logic [7:0]          entry_count
);

    typedef enum logic [3:0] {
        IDLE,
        RD_DESC,
        WAIT_DESC,
        RD_PAY,
        WAIT_PAY,
        WRITE,
`ifdef CFG_CHECKSUM_EN
        RD_SUM,
        WAIT_SUM,
`endif
        FINISH,
        ERROR
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [7:0]        LUT_LIMIT = 8'(NUM_LUT);
    localparam logic [7:0]        SW_LIMIT  = 8'(NUM_SW);
    localparam logic [1:0]        TYPE_LUT  = 2'b00;
    localparam logic [1:0]        TYPE_SW   = 2'b01;
    localparam logic [1:0]        TYPE_RSV  = 2'b10;
    localparam logic [1:0]        TYPE_END  = 2'b11;

    state_t      state_reg;
    logic        desc_type_reg;
    logic [7:0]  desc_index_reg;
    logic [1:0]  pend_code_reg;
`ifdef CFG_CHECKSUM_EN
    logic [31:0] sum_reg;
`endif

    logic [1:0]  desc_kind;
    logic [7:0]  desc_idx;
    logic        desc_bad;
    logic        addr_at_last;

    assign desc_kind    = bus.img_data[31:30];
    assign desc_idx     = bus.img_data[7:0];
    assign desc_bad     = (desc_kind == TYPE_RSV)
                       || ((desc_kind == TYPE_LUT) && (desc_idx >= LUT_LIMIT))
                       || ((desc_kind == TYPE_SW)  && (desc_idx >= SW_LIMIT));
    assign addr_at_last = (bus.img_addr == ADDR_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            desc_type_reg  <= 1'b0;
            desc_index_reg <= 8'd0;
            pend_code_reg  <= 2'b00;
`ifdef CFG_CHECKSUM_EN
            sum_reg        <= 32'd0;
`endif
            bus.img_rd     <= 1'b0;
            bus.img_addr   <= '0;
            bus.cfg_we     <= 1'b0;
            bus.cfg_type   <= 1'b0;
            bus.cfg_index  <= 8'd0;
            bus.cfg_data   <= 33'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            err_code       <= 2'b00;
            entry_count    <= 8'd0;
        end else begin
            // Strobes are single-cycle; only the transitions below re-assert them.
            bus.img_rd <= 1'b0;
            bus.cfg_we <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        done         <= 1'b0;
                        error        <= 1'b0;
                        err_code     <= 2'b00;
                        entry_count  <= 8'd0;
                        bus.img_addr <= '0;
                        busy         <= 1'b1;
                        bus.img_rd   <= 1'b1;
`ifdef CFG_CHECKSUM_EN
                        sum_reg      <= 32'd0;
`endif
                        state_reg    <= RD_DESC;
                    end
                end

                RD_DESC: state_reg <= WAIT_DESC;

                WAIT_DESC: begin
                    if (desc_kind == TYPE_END) begin
`ifdef CFG_CHECKSUM_EN
                        if (addr_at_last) begin
                            pend_code_reg <= 2'b10;
                            state_reg     <= ERROR;
                        end else begin
                            bus.img_addr  <= bus.img_addr + 1'b1;
                            bus.img_rd    <= 1'b1;
                            state_reg     <= RD_SUM;
                        end
`else
                        state_reg <= FINISH;
`endif
                    end else if (desc_bad) begin
                        pend_code_reg <= 2'b01;
                        state_reg     <= ERROR;
                    end else if (addr_at_last) begin
                        pend_code_reg <= 2'b10;
                        state_reg     <= ERROR;
                    end else begin
                        desc_type_reg  <= desc_kind[0];
                        desc_index_reg <= desc_idx;
                        bus.img_addr   <= bus.img_addr + 1'b1;
                        bus.img_rd     <= 1'b1;
                        state_reg      <= RD_PAY;
                    end
                end

                RD_PAY: state_reg <= WAIT_PAY;

                WAIT_PAY: begin
                    // Target fields change only here, so they stay stable between strobes.
                    bus.cfg_type  <= desc_type_reg;
                    bus.cfg_index <= desc_index_reg;
                    bus.cfg_data  <= {1'b0, bus.img_data};
                    bus.cfg_we    <= 1'b1;
`ifdef CFG_CHECKSUM_EN
                    sum_reg       <= sum_reg ^ bus.img_data;
`endif
                    state_reg     <= WRITE;
                end

                WRITE: begin
                    if (entry_count != 8'hFF) begin
                        entry_count <= entry_count + 8'd1;
                    end
                    if (addr_at_last) begin
                        pend_code_reg <= 2'b10;
                        state_reg     <= ERROR;
                    end else begin
                        bus.img_addr  <= bus.img_addr + 1'b1;
                        bus.img_rd    <= 1'b1;
                        state_reg     <= RD_DESC;
                    end
                end

`ifdef CFG_CHECKSUM_EN
                RD_SUM: state_reg <= WAIT_SUM;

                WAIT_SUM: begin
                    if (bus.img_data == sum_reg) begin
                        state_reg <= FINISH;
                    end else begin
                        pend_code_reg <= 2'b11;
                        state_reg     <= ERROR;
                    end
                end
`endif

                FINISH: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end

                ERROR: begin
                    error     <= 1'b1;
                    err_code  <= pend_code_reg;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_image_loader.sv
// Scoreboard bench for cfg_image_loader: directed images, expected writes queued, monitor checks each strobe.
module tb_cfg_image_loader;

`ifdef CFG_CHECKSUM_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, error;
    logic [1:0] err_code;
    logic [7:0] entry_count;

    cfg_image_loader_if #(.ADDR_W(8)) bus ();

    cfg_image_loader #(.ADDR_W(8), .NUM_LUT(24), .NUM_SW(17)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code),
        .entry_count (entry_count)
    );

    always #5 clock = ~clock;

    // Synchronous image memory: data valid the cycle after img_rd.
    logic [31:0] mem [256];
    always @(posedge clock) begin
        if (bus.img_rd) bus.img_data <= mem[bus.img_addr];
    end

    int          checks   = 0;
    int          failures = 0;
    logic [41:0] sb [$];
    logic [7:0]  last_rd_addr = 8'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_wr(input logic t, input logic [7:0] idx, input logic [31:0] data);
        sb.push_back({t, idx, 1'b0, data});
    endtask

    // Monitor: every configuration strobe is checked against the head of the scoreboard.
    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.img_rd) last_rd_addr <= bus.img_addr;
            if (bus.cfg_we) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_wr: got type=%0d idx=%0d data=0x%0h expected none",
                             bus.cfg_type, bus.cfg_index, bus.cfg_data);
                end else begin
                    logic [41:0] e;
                    e = sb.pop_front();
                    $display("WR type=%0d idx=%0d data=0x%09h", bus.cfg_type, bus.cfg_index, bus.cfg_data);
                    chk("cfg_wr", {22'd0, bus.cfg_type, bus.cfg_index, bus.cfg_data}, {22'd0, e});
                end
            end
        end
    end

    task automatic fill_mem(input logic [31:0] val);
        for (int i = 0; i < 256; i++) mem[i] = val;
    endtask

    task automatic load_clean();
        fill_mem(32'hC000_0000);
        mem[0] = 32'h0000_0000;
        mem[1] = 32'hCCCC_AAAA;
        mem[2] = 32'h4000_0003;
        mem[3] = 32'h0000_0008;
        mem[4] = 32'hC000_0000;
        mem[5] = 32'hCCCC_AAA2;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_status"}, {51'd0, busy, done, error, err_code, entry_count}, 64'd0);
        chk({tag, "_img"},    {55'd0, bus.img_rd, bus.img_addr}, 64'd0);
        chk({tag, "_cfg"},    {21'd0, bus.cfg_we, bus.cfg_type, bus.cfg_index, bus.cfg_data}, 64'd0);
    endtask

    task automatic run_load(input string tag, input int exp_lat, input logic exp_err,
                            input logic [1:0] exp_code, input int exp_cnt, input int restart_at);
        int cyc;
        bit fin;
        cyc = 0;
        fin = 1'b0;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        chk({tag, "_busy_hi"}, {63'd0, busy}, 64'd1);
        while (!fin && cyc < 2000) begin
            @(posedge clock);
            cyc++;
            #1;
            if (restart_at > 0) start = (cyc == restart_at);
            if (done || error) fin = 1'b1;
        end
        start = 1'b0;
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no done/error expected within 2000 cycles", tag);
        end
        $display("LOAD %s latency=%0d done=%0d error=%0d code=%0d count=%0d",
                 tag, cyc, done, error, err_code, entry_count);
        chk({tag, "_latency"}, cyc, exp_lat);
        chk({tag, "_done"},  {63'd0, done},  {63'd0, !exp_err});
        chk({tag, "_error"}, {63'd0, error}, {63'd0, exp_err});
        chk({tag, "_code"},  {62'd0, err_code}, {62'd0, exp_code});
        chk({tag, "_count"}, {56'd0, entry_count}, exp_cnt);
        chk({tag, "_busy_lo"}, {63'd0, busy}, 64'd0);
        chk({tag, "_sb_empty"}, sb.size(), 64'd0);
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        fill_mem(32'hC000_0000);

        // Reset state
        repeat (3) @(posedge clock);
        #1 check_all_zero("reset");
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Clean load
        load_clean();
        exp_wr(1'b0, 8'd0, 32'hCCCC_AAAA);
        exp_wr(1'b1, 8'd3, 32'h0000_0008);
        run_load("clean", 13 + EXTRA, 1'b0, 2'b00, 2, 0);

        // Highest valid LUT and switch indices
        fill_mem(32'hC000_0000);
        mem[0] = 32'h0000_0017; mem[1] = 32'h1111_1111;
        mem[2] = 32'h4000_0010; mem[3] = 32'h2222_2222;
        mem[4] = 32'hC000_0000; mem[5] = 32'h3333_3333;
        exp_wr(1'b0, 8'd23, 32'h1111_1111);
        exp_wr(1'b1, 8'd16, 32'h2222_2222);
        run_load("bound", 13 + EXTRA, 1'b0, 2'b00, 2, 0);

        // Bad descriptors: LUT 24, switch 17, reserved type
        fill_mem(32'hC000_0000);
        mem[0] = 32'h0000_0018;
        run_load("bad_lut", 3, 1'b1, 2'b01, 0, 0);
        mem[0] = 32'h4000_0011;
        run_load("bad_sw", 3, 1'b1, 2'b01, 0, 0);
        mem[0] = 32'h8000_0001;
        run_load("bad_rsv", 3, 1'b1, 2'b01, 0, 0);

        // Overflow: 128 valid LUT entries, no END
        for (int i = 0; i < 128; i++) begin
            mem[2*i]   = 32'(i % 24);
            mem[2*i+1] = 32'h0001_0000 + 32'(i);
            exp_wr(1'b0, 8'(i % 24), 32'h0001_0000 + 32'(i));
        end
        run_load("ovf", 641, 1'b1, 2'b10, 128, 0);
        chk("ovf_last_rd", {56'd0, last_rd_addr}, 64'hFF);

        // Start while busy (pulsed during WAIT_PAY of the first entry)
        load_clean();
        exp_wr(1'b0, 8'd0, 32'hCCCC_AAAA);
        exp_wr(1'b1, 8'd3, 32'h0000_0008);
        run_load("restart", 13 + EXTRA, 1'b0, 2'b00, 2, 3);

        // Reset during the second WRITE
        load_clean();
        exp_wr(1'b0, 8'd0, 32'hCCCC_AAAA);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        n = 0;
        for (int c = 0; c < 40 && n < 2; c++) begin
            @(posedge clock);
            #2;
            if (bus.cfg_we) n++;
        end
        chk("mid_rst_reached", n, 2);
        reset_n = 1'b0;
        #1 check_all_zero("mid_rst");
        repeat (3) @(posedge clock);
        #1 chk("mid_rst_sb", sb.size(), 64'd0);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock);
        #1;
        exp_wr(1'b0, 8'd0, 32'hCCCC_AAAA);
        exp_wr(1'b1, 8'd3, 32'h0000_0008);
        run_load("reload", 13 + EXTRA, 1'b0, 2'b00, 2, 0);

`ifdef CFG_CHECKSUM_EN
        // Checksum mismatch
        load_clean();
        mem[5] = 32'h0000_0000;
        exp_wr(1'b0, 8'd0, 32'hCCCC_AAAA);
        exp_wr(1'b1, 8'd3, 32'h0000_0008);
        run_load("sum_bad", 15, 1'b1, 2'b11, 2, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
